memory_slot_controller: RTL and testbench

//  Sequences pushbutton memory commands (MS/MR/MC/M+) for the calculator against a

---
 rtl/memory_slot_controller_if.sv | 33 +++
 rtl/memory_slot_controller.sv | 189 ++++++++++++++++++
 tb/tb_memory_slot_controller.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_slot_controller_if.sv
// Command/status bundle between the pushbutton encoder, the display digit
// registers and memory_slot_controller.
interface memory_slot_controller_if #(
    parameter int SLOT_W = 2
);
    logic [1:0]        pushbuttons;
    logic              pushButtonSignal;
    logic [SLOT_W-1:0] slot_sel;
    logic [3:0]        digit1;
    logic [3:0]        digit2;
    logic [3:0]        digit3;
    logic [3:0]        mem_digit1;
    logic [3:0]        mem_digit2;
    logic [3:0]        mem_digit3;
    logic              recall_valid;
    logic              busy;
    logic              cmd_done;
    logic              cmd_dropped;
    logic              bcd_error;
    logic              overflow;

    modport master (
        output pushbuttons, pushButtonSignal, slot_sel, digit1, digit2, digit3,
        input  mem_digit1, mem_digit2, mem_digit3, recall_valid, busy,
               cmd_done, cmd_dropped, bcd_error, overflow
    );

    modport slave (
        input  pushbuttons, pushButtonSignal, slot_sel, digit1, digit2, digit3,
        output mem_digit1, mem_digit2, mem_digit3, recall_valid, busy,
               cmd_done, cmd_dropped, bcd_error, overflow
    );
endinterface

// File: rtl/memory_slot_controller.sv
// Calculator memory command sequencer (MS/MR/MC/M+) over 3-digit BCD slots.
// Define MEM_ADD_EN to build the digit-serial M+ accumulate path.
module memory_slot_controller #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
) (
    input logic                     clock,
    input logic                     reset_n,
    memory_slot_controller_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] STORE  = 3'd1;
    localparam logic [2:0] RECALL = 3'd2;
    localparam logic [2:0] CLEAR  = 3'd3;
`ifdef MEM_ADD_EN
    localparam logic [2:0] ADD1   = 3'd4;
    localparam logic [2:0] ADD2   = 3'd5;
    localparam logic [2:0] ADD3   = 3'd6;
`endif
    localparam logic [2:0] DONE   = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [11:0]       in_q, in_d;
    logic [11:0]       mem_q [NUM_SLOTS];
    logic [11:0]       mem_d [NUM_SLOTS];
    logic [11:0]       recall_q, recall_d;
    logic              recall_valid_q, recall_valid_d;
    logic              dropped_q, dropped_d;
    logic              bcd_err_q, bcd_err_d;
    logic              digits_ok;
`ifdef MEM_ADD_EN
    logic              ovf_q, ovf_d;
    logic              carry_q, carry_d;
    logic [7:0]        acc_q, acc_d;
    logic [11:0]       slot_word;
    logic [3:0]        add_a, add_b, add_res;
    logic [4:0]        add_sum;
    logic              add_carry;
`endif

    assign digits_ok = (bus.digit1 <= 4'd9) && (bus.digit2 <= 4'd9) && (bus.digit3 <= 4'd9);

`ifdef MEM_ADD_EN
    // One BCD digit per ADD state, ones digit first; carry ripples through carry_q.
    always_comb begin
        slot_word = mem_q[slot_q];
        case (state_q)
            ADD2:    begin add_a = slot_word[7:4];  add_b = in_q[7:4];  end
            ADD3:    begin add_a = slot_word[11:8]; add_b = in_q[11:8]; end
            default: begin add_a = slot_word[3:0];  add_b = in_q[3:0];  end
        endcase
        add_sum   = {1'b0, add_a} + {1'b0, add_b} + {4'd0, carry_q};
        add_carry = add_sum > 5'd9;
        add_res   = add_carry ? 4'(add_sum - 5'd10) : add_sum[3:0];
    end
`endif

    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        in_d           = in_q;
        mem_d          = mem_q;
        recall_d       = recall_q;
        recall_valid_d = 1'b0;
        dropped_d      = 1'b0;
        bcd_err_d      = 1'b0;
`ifdef MEM_ADD_EN
        ovf_d          = ovf_q;
        carry_d        = carry_q;
        acc_d          = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.pushButtonSignal) begin
                    slot_d = bus.slot_sel;
                    in_d   = {bus.digit3, bus.digit2, bus.digit1};
                    case (bus.pushbuttons)
                        2'b01: begin
                            if (digits_ok) state_d = STORE;
                            else begin
                                bcd_err_d = 1'b1;
                                dropped_d = 1'b1;
                            end
                        end
                        2'b10: state_d = RECALL;
                        2'b11: state_d = CLEAR;
                        default: begin
`ifdef MEM_ADD_EN
                            if (digits_ok) begin
                                state_d = ADD1;
                                carry_d = 1'b0;
                            end else begin
                                bcd_err_d = 1'b1;
                                dropped_d = 1'b1;
                            end
`else
                            dropped_d = 1'b1;
`endif
                        end
                    endcase
                end
            end
            STORE: begin
                mem_d[slot_q] = in_q;
                state_d       = DONE;
            end
            RECALL: begin
                recall_d       = mem_q[slot_q];
                recall_valid_d = 1'b1;
                state_d        = DONE;
            end
            CLEAR: begin
                mem_d   = '{default: '0};
`ifdef MEM_ADD_EN
                ovf_d   = 1'b0;
`endif
                state_d = DONE;
            end
`ifdef MEM_ADD_EN
            ADD1: begin
                acc_d[3:0] = add_res;
                carry_d    = add_carry;
                state_d    = ADD2;
            end
            ADD2: begin
                acc_d[7:4] = add_res;
                carry_d    = add_carry;
                state_d    = ADD3;
            end
            // Slot is only written here, so an aborted M+ leaves it untouched.
            ADD3: begin
                mem_d[slot_q] = {add_res, acc_q};
                if (add_carry) ovf_d = 1'b1;
                state_d       = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.pushButtonSignal && (state_q != IDLE)) dropped_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            slot_q         <= '0;
            in_q           <= '0;
            mem_q          <= '{default: '0};
            recall_q       <= '0;
            recall_valid_q <= 1'b0;
            dropped_q      <= 1'b0;
            bcd_err_q      <= 1'b0;
`ifdef MEM_ADD_EN
            ovf_q          <= 1'b0;
            carry_q        <= 1'b0;
            acc_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            in_q           <= in_d;
            mem_q          <= mem_d;
            recall_q       <= recall_d;
            recall_valid_q <= recall_valid_d;
            dropped_q      <= dropped_d;
            bcd_err_q      <= bcd_err_d;
`ifdef MEM_ADD_EN
            ovf_q          <= ovf_d;
            carry_q        <= carry_d;
            acc_q          <= acc_d;
`endif
        end
    end

    assign bus.mem_digit1   = recall_q[3:0];
    assign bus.mem_digit2   = recall_q[7:4];
    assign bus.mem_digit3   = recall_q[11:8];
    assign bus.recall_valid = recall_valid_q;
    assign bus.busy         = (state_q != IDLE) && (state_q != DONE);
    assign bus.cmd_done     = (state_q == DONE);
    assign bus.cmd_dropped  = dropped_q;
    assign bus.bcd_error    = bcd_err_q;
`ifdef MEM_ADD_EN
    assign bus.overflow     = ovf_q;
`else
    assign bus.overflow     = 1'b0;
`endif
endmodule

// File: tb/tb_memory_slot_controller.sv
// Randomized bench for memory_slot_controller; reference model keeps slots as
// decimal integers 0..999 and works with plain arithmetic.
`timescale 1ns/1ps
module tb_memory_slot_controller;
    localparam logic [1:0] C_MP = 2'b00;
    localparam logic [1:0] C_MS = 2'b01;
    localparam logic [1:0] C_MR = 2'b10;
    localparam logic [1:0] C_MC = 2'b11;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    int   m_slot [4];
    int   m_recall = 0;
    bit   m_ovf = 1'b0;

    memory_slot_controller_if #(.SLOT_W(2)) bus ();

    memory_slot_controller #(.NUM_SLOTS(4), .SLOT_W(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
        $fatal(1);
    end

    function automatic int recalled();
        return int'(bus.mem_digit3) * 100 + int'(bus.mem_digit2) * 10 + int'(bus.mem_digit1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot[i] = 0;
        m_recall = 0;
        m_ovf = 1'b0;
    endtask

    task automatic scramble_inputs();
        bus.pushbuttons = 2'($urandom);
        bus.slot_sel    = 2'($urandom);
        bus.digit1      = 4'($urandom);
        bus.digit2      = 4'($urandom);
        bus.digit3      = 4'($urandom);
    endtask

    // Issues one strobe, then watches outputs from cycle N+1 onwards (bounded).
    task automatic do_cmd(input logic [1:0] code, input int slot, input int d3, input int d2, input int d1,
                          output int lat, output bit drop, output bit berr, output bit rv, output bit busy1);
        @(negedge clock);
        bus.pushbuttons      = code;
        bus.slot_sel         = 2'(slot);
        bus.digit3           = 4'(d3);
        bus.digit2           = 4'(d2);
        bus.digit1           = 4'(d1);
        bus.pushButtonSignal = 1'b1;
        @(negedge clock);
        bus.pushButtonSignal = 1'b0;
        scramble_inputs();
        drop  = bus.cmd_dropped;
        berr  = bus.bcd_error;
        busy1 = bus.busy;
        lat   = 0;
        rv    = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (bus.recall_valid) rv = 1'b1;
            if (bus.cmd_done) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        bus.pushButtonSignal = 1'b0;
        scramble_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.cmd_done, bus.recall_valid, bus.cmd_dropped, bus.bcd_error, bus.overflow} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000000", {bus.busy, bus.cmd_done, bus.recall_valid,
                     bus.cmd_dropped, bus.bcd_error, bus.overflow});
        end
        checks++;
        if ({bus.mem_digit3, bus.mem_digit2, bus.mem_digit1} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mem_digits: got %h want 000", {bus.mem_digit3, bus.mem_digit2, bus.mem_digit1});
        end
    endtask

    task automatic test_recall_empty();
        int lat; bit drop, berr, rv, b1;
        do_cmd(C_MR, 2, 0, 0, 0, lat, drop, berr, rv, b1);
        checks++;
        if (lat !== 2 || rv !== 1'b1 || b1 !== 1'b1 || drop !== 1'b0) begin
            failures++;
            $display("FAIL mr_empty_handshake: lat=%0d rv=%0b busy=%0b drop=%0b want 2 1 1 0", lat, rv, b1, drop);
        end
        checks++;
        if (recalled() !== 0) begin
            failures++;
            $display("FAIL mr_empty_value: got %0d want 0", recalled());
        end
    endtask

    task automatic test_store_recall();
        int lat; bit drop, berr, rv, b1;
        do_cmd(C_MS, 1, 1, 2, 3, lat, drop, berr, rv, b1);
        m_slot[1] = 123;
        checks++;
        if (lat !== 2 || rv !== 1'b0 || b1 !== 1'b1) begin
            failures++;
            $display("FAIL ms_handshake: lat=%0d rv=%0b busy=%0b want 2 0 1", lat, rv, b1);
        end
        do_cmd(C_MR, 1, 0, 0, 0, lat, drop, berr, rv, b1);
        m_recall = m_slot[1];
        checks++;
        if (lat !== 2 || rv !== 1'b1 || recalled() !== 123) begin
            failures++;
            $display("FAIL mr_slot1: lat=%0d rv=%0b value=%0d want 2 1 123", lat, rv, recalled());
        end
    endtask

    task automatic test_random_ms_mr();
        int lat; bit drop, berr, rv, b1;
        int s, d3, d2, d1;
        bit bad;
        for (int it = 0; it < 24; it++) begin
            s   = $urandom_range(0, 3);
            bad = ($urandom_range(0, 4) == 0);
            d3  = $urandom_range(0, 9);
            d2  = $urandom_range(0, 9);
            d1  = bad ? $urandom_range(10, 15) : $urandom_range(0, 9);
            do_cmd(C_MS, s, d3, d2, d1, lat, drop, berr, rv, b1);
            if (!bad) m_slot[s] = d3 * 100 + d2 * 10 + d1;
            checks++;
            if (bad ? (berr !== 1'b1 || drop !== 1'b1 || lat !== 0 || b1 !== 1'b0)
                    : (berr !== 1'b0 || drop !== 1'b0 || lat !== 2)) begin
                failures++;
                $display("FAIL rand_ms_handshake: it=%0d bad=%0b berr=%0b drop=%0b lat=%0d busy=%0b",
                         it, bad, berr, drop, lat, b1);
            end
            checks++;
            if (recalled() !== m_recall) begin
                failures++;
                $display("FAIL rand_ms_holds_recall: got %0d want %0d", recalled(), m_recall);
            end
            s = $urandom_range(0, 3);
            do_cmd(C_MR, s, 0, 0, 0, lat, drop, berr, rv, b1);
            m_recall = m_slot[s];
            checks++;
            if (lat !== 2 || rv !== 1'b1 || recalled() !== m_recall) begin
                failures++;
                $display("FAIL rand_mr: slot=%0d lat=%0d rv=%0b got %0d want %0d", s, lat, rv, recalled(), m_recall);
            end
        end
    endtask

    task automatic test_bcd_error();
        int lat; bit drop, berr, rv, b1;
        do_cmd(C_MS, 1, 0, 0, 'hC, lat, drop, berr, rv, b1);
        checks++;
        if (berr !== 1'b1 || drop !== 1'b1 || lat !== 0) begin
            failures++;
            $display("FAIL ms_bcd_error: berr=%0b drop=%0b lat=%0d want 1 1 0", berr, drop, lat);
        end
        do_cmd(C_MR, 1, 0, 0, 0, lat, drop, berr, rv, b1);
        m_recall = m_slot[1];
        checks++;
        if (recalled() !== m_recall) begin
            failures++;
            $display("FAIL bcd_error_slot_kept: got %0d want %0d", recalled(), m_recall);
        end
    endtask

    task automatic test_clear();
        int lat; bit drop, berr, rv, b1;
        for (int s = 0; s < 4; s++) begin
            do_cmd(C_MS, s, $urandom_range(1, 9), $urandom_range(0, 9), $urandom_range(0, 9), lat, drop, berr, rv, b1);
        end
        do_cmd(C_MC, $urandom_range(0, 3), 0, 0, 0, lat, drop, berr, rv, b1);
        model_reset_slots_only();
        checks++;
        if (lat !== 2 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL mc_handshake: lat=%0d ovf=%0b want 2 0", lat, bus.overflow);
        end
        for (int s = 0; s < 4; s++) begin
            do_cmd(C_MR, s, 0, 0, 0, lat, drop, berr, rv, b1);
            m_recall = m_slot[s];
            checks++;
            if (recalled() !== 0) begin
                failures++;
                $display("FAIL mc_cleared: slot=%0d got %0d want 0", s, recalled());
            end
        end
    endtask

    task automatic model_reset_slots_only();
        for (int i = 0; i < 4; i++) m_slot[i] = 0;
        m_ovf = 1'b0;
    endtask

    // Strobe held across three edges: accepted, dropped in STORE, dropped in DONE.
    task automatic test_busy_drop_ms();
        @(negedge clock);
        bus.pushbuttons = C_MS; bus.slot_sel = 2'd3;
        bus.digit3 = 4'd4; bus.digit2 = 4'd5; bus.digit1 = 4'd6;
        bus.pushButtonSignal = 1'b1;
        m_slot[3] = 456;
        @(negedge clock);
        bus.pushbuttons = C_MC; bus.digit1 = 4'd1;
        checks++;
        if (bus.busy !== 1'b1 || bus.cmd_dropped !== 1'b0) begin
            failures++;
            $display("FAIL busy_drop_accept: busy=%0b drop=%0b want 1 0", bus.busy, bus.cmd_dropped);
        end
        @(negedge clock);
        checks++;
        if (bus.cmd_dropped !== 1'b1 || bus.cmd_done !== 1'b1) begin
            failures++;
            $display("FAIL busy_drop_store: drop=%0b done=%0b want 1 1", bus.cmd_dropped, bus.cmd_done);
        end
        @(negedge clock);
        bus.pushButtonSignal = 1'b0;
        checks++;
        if (bus.cmd_dropped !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_done !== 1'b0) begin
            failures++;
            $display("FAIL busy_drop_done: drop=%0b busy=%0b done=%0b want 1 0 0",
                     bus.cmd_dropped, bus.busy, bus.cmd_done);
        end
        begin
            int lat; bit drop, berr, rv, b1;
            do_cmd(C_MR, 3, 0, 0, 0, lat, drop, berr, rv, b1);
            m_recall = m_slot[3];
            checks++;
            if (recalled() !== 456) begin
                failures++;
                $display("FAIL busy_drop_result: got %0d want 456", recalled());
            end
        end
    endtask

`ifdef MEM_ADD_EN
    task automatic madd_check(input int s, input int d3, input int d2, input int d1, input string tag);
        int lat; bit drop, berr, rv, b1;
        int sum;
        do_cmd(C_MP, s, d3, d2, d1, lat, drop, berr, rv, b1);
        sum = m_slot[s] + d3 * 100 + d2 * 10 + d1;
        if (sum >= 1000) m_ovf = 1'b1;
        m_slot[s] = sum % 1000;
        checks++;
        if (lat !== 4 || b1 !== 1'b1 || drop !== 1'b0 || bus.overflow !== m_ovf || recalled() !== m_recall) begin
            failures++;
            $display("FAIL %s_handshake: lat=%0d busy=%0b drop=%0b ovf=%0b hold=%0d want 4 1 0 %0b %0d",
                     tag, lat, b1, drop, bus.overflow, recalled(), m_ovf, m_recall);
        end
        do_cmd(C_MR, s, 0, 0, 0, lat, drop, berr, rv, b1);
        m_recall = m_slot[s];
        checks++;
        if (recalled() !== m_recall) begin
            failures++;
            $display("FAIL %s_value: slot=%0d got %0d want %0d", tag, s, recalled(), m_recall);
        end
    endtask

    task automatic test_madd();
        int lat; bit drop, berr, rv, b1;
        do_cmd(C_MS, 0, 0, 9, 9, lat, drop, berr, rv, b1);
        m_slot[0] = 99;
        madd_check(0, 0, 0, 1, "madd_099p001");
        madd_check(0, 9, 0, 0, "madd_wrap");
        checks++;
        if (bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL madd_overflow_set: got %0b want 1", bus.overflow);
        end
        do_cmd(C_MC, 0, 0, 0, 0, lat, drop, berr, rv, b1);
        model_reset_slots_only();
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL mc_clears_overflow: got %0b want 0", bus.overflow);
        end
        for (int it = 0; it < 16; it++) begin
            madd_check($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                       "madd_rand");
        end
        do_cmd(C_MP, 2, 0, 4'hA, 0, lat, drop, berr, rv, b1);
        checks++;
        if (berr !== 1'b1 || drop !== 1'b1 || lat !== 0) begin
            failures++;
            $display("FAIL madd_bcd_error: berr=%0b drop=%0b lat=%0d want 1 1 0", berr, drop, lat);
        end
    endtask

    task automatic test_busy_drop_madd();
        int lat; bit drop, berr, rv, b1;
        int exp;
        @(negedge clock);
        bus.pushbuttons = C_MP; bus.slot_sel = 2'd1;
        bus.digit3 = 4'd1; bus.digit2 = 4'd1; bus.digit1 = 4'd1;
        bus.pushButtonSignal = 1'b1;
        exp = m_slot[1] + 111;
        if (exp >= 1000) m_ovf = 1'b1;
        m_slot[1] = exp % 1000;
        @(negedge clock);
        bus.pushbuttons = C_MS; bus.digit1 = 4'd7;
        @(negedge clock);
        bus.pushButtonSignal = 1'b0;
        checks++;
        if (bus.cmd_dropped !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL madd_busy_drop: drop=%0b busy=%0b want 1 1", bus.cmd_dropped, bus.busy);
        end
        repeat (3) @(negedge clock);
        do_cmd(C_MR, 1, 0, 0, 0, lat, drop, berr, rv, b1);
        m_recall = m_slot[1];
        checks++;
        if (recalled() !== m_recall) begin
            failures++;
            $display("FAIL madd_busy_drop_result: got %0d want %0d", recalled(), m_recall);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit drop, berr, rv, b1;
        @(negedge clock);
        bus.pushbuttons = C_MP; bus.slot_sel = 2'd0;
        bus.digit3 = 4'd9; bus.digit2 = 4'd9; bus.digit1 = 4'd9;
        bus.pushButtonSignal = 1'b1;
        @(negedge clock);
        bus.pushButtonSignal = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.cmd_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_add: busy=%0b ovf=%0b done=%0b want 0 0 0", bus.busy, bus.overflow, bus.cmd_done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        do_cmd(C_MR, 0, 0, 0, 0, lat, drop, berr, rv, b1);
        checks++;
        if (recalled() !== 0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_slot: got %0d ovf=%0b want 0 0", recalled(), bus.overflow);
        end
    endtask
`else
    task automatic test_madd_disabled();
        int lat; bit drop, berr, rv, b1;
        do_cmd(C_MP, 1, 0, 0, 1, lat, drop, berr, rv, b1);
        checks++;
        if (drop !== 1'b1 || berr !== 1'b0 || lat !== 0 || b1 !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL madd_disabled: drop=%0b berr=%0b lat=%0d busy=%0b ovf=%0b want 1 0 0 0 0",
                     drop, berr, lat, b1, bus.overflow);
        end
        do_cmd(C_MR, 1, 0, 0, 0, lat, drop, berr, rv, b1);
        m_recall = m_slot[1];
        checks++;
        if (recalled() !== m_recall) begin
            failures++;
            $display("FAIL madd_disabled_slot: got %0d want %0d", recalled(), m_recall);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit drop, berr, rv, b1;
        @(negedge clock);
        bus.pushbuttons = C_MS; bus.slot_sel = 2'd2;
        bus.digit3 = 4'd8; bus.digit2 = 4'd8; bus.digit1 = 4'd8;
        bus.pushButtonSignal = 1'b1;
        @(negedge clock);
        bus.pushButtonSignal = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_store: busy=%0b done=%0b want 0 0", bus.busy, bus.cmd_done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        do_cmd(C_MR, 2, 0, 0, 0, lat, drop, berr, rv, b1);
        checks++;
        if (recalled() !== 0) begin
            failures++;
            $display("FAIL reset_mid_slot: got %0d want 0", recalled());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_recall_empty();
        test_store_recall();
        test_random_ms_mr();
        test_bcd_error();
        test_busy_drop_ms();
        test_clear();
`ifdef MEM_ADD_EN
        test_madd();
        test_busy_drop_madd();
`else
        test_madd_disabled();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
